// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous memory between fetch, data and an
// external port; fixed priority d > f > x with aging promotion of x.
module mem_port_arbiter #(
    parameter int unsigned AW       = 14,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            hold,
    input  logic            f_req,
    input  logic [AW-1:0]   f_addr,
    output logic            f_gnt,
    output logic            f_rvalid,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    input  logic            x_req,
    input  logic            x_we,
    input  logic [AW-1:0]   x_addr,
    input  logic [DW-1:0]   x_wdata,
    input  logic [DW/8-1:0] x_be,
    output logic            x_gnt,
    output logic            x_rvalid,
    output logic [DW-1:0]   rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_D    = 2'd2,
        OWN_X    = 2'd3
    } owner_e;

    owner_e          owner_q, owner_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            x_promote;

    // Grant selection: x jumps the queue once it has been refused MAX_WAIT times
    always_comb begin
        f_gnt     = 1'b0;
        d_gnt     = 1'b0;
        x_gnt     = 1'b0;
        x_promote = x_req && (wait_cnt_q == CW'(MAX_WAIT));
        if (!RST && !hold) begin
            if (x_promote) begin
                x_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end else if (x_req) begin
                x_gnt = 1'b1;
            end
        end
    end

    // Memory strobe mux; fetch is always a full-word read
    always_comb begin
        mem_en    = f_gnt | d_gnt | x_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
        end else if (x_gnt) begin
            mem_we    = x_we;
            mem_addr  = x_addr;
            mem_wdata = x_wdata;
            mem_be    = x_be;
        end else if (f_gnt) begin
            mem_addr  = f_addr;
            mem_be    = '1;
        end
    end

    // Next owner of the read-data bus and next aging count
    always_comb begin
        owner_d    = OWN_NONE;
        wait_cnt_d = wait_cnt_q;
        if (f_gnt) begin
            owner_d = OWN_F;
        end else if (d_gnt && !d_we) begin
            owner_d = OWN_D;
        end else if (x_gnt && !x_we) begin
            owner_d = OWN_X;
        end

        if (!hold) begin
            if (!x_req || x_gnt) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q < CW'(MAX_WAIT)) begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_q    <= OWN_NONE;
            wait_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A response pending when reset arrives is dropped
    assign f_rvalid = !RST && (owner_q == OWN_F);
    assign d_rvalid = !RST && (owner_q == OWN_D);
    assign x_rvalid = !RST && (owner_q == OWN_X);
    assign rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written aging/hold
// sequences and random traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW       = 14;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic            CLK = 1'b0;
    logic            RST, hold;
    logic            f_req, f_gnt, f_rvalid;
    logic [AW-1:0]   f_addr;
    logic            d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic [3:0]      d_be;
    logic            x_req, x_we, x_gnt, x_rvalid;
    logic [AW-1:0]   x_addr;
    logic [DW-1:0]   x_wdata;
    logic [3:0]      x_be;
    logic [DW-1:0]   rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [3:0]      mem_be;
    logic [DW-1:0]   mem_rdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST), .hold(hold),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_be(x_be),
        .x_gnt(x_gnt), .x_rvalid(x_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          rst, hold;
        logic          f_req;
        logic [AW-1:0] f_addr;
        logic          d_req, d_we;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] d_wdata;
        logic [3:0]    d_be;
        logic          x_req, x_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wdata;
        logic [3:0]    x_be;
    } stim_t;

    typedef struct {
        stim_t         s;
        logic [2:0]    gnt;   // {x,d,f}
        logic [2:0]    rv;    // {x,d,f}
        bit            chk_rd;
        logic [DW-1:0] rd;
    } vec_t;

    // Memory array attached to the arbiter, plus the model's own shadow copy
    logic [DW-1:0] tb_mem [16];
    logic [DW-1:0] shadow [16];

    always @(posedge CLK) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) tb_mem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= tb_mem[mem_addr[3:0]];
            end
        end
    end

    // Reference model state: who owns the next response, aging count, read value
    int            m_owner;
    int            m_wait;
    logic [DW-1:0] m_last_rd;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic rst, input logic hld,
                                 input logic fr, input logic [AW-1:0] fa,
                                 input logic dr, input logic dwe, input logic [AW-1:0] da,
                                 input logic [DW-1:0] dwd, input logic [3:0] dbe,
                                 input logic xr, input logic xwe, input logic [AW-1:0] xa);
        stim_t s;
        s.rst = rst;   s.hold = hld;
        s.f_req = fr;  s.f_addr = fa;
        s.d_req = dr;  s.d_we = dwe; s.d_addr = da; s.d_wdata = dwd; s.d_be = dbe;
        s.x_req = xr;  s.x_we = xwe; s.x_addr = xa;
        s.x_wdata = {16'hA5A5, 2'b00, xa}; s.x_be = 4'hF;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, '0, 0, 0, '0, '0, '0, 0, 0, '0);
    endfunction

    // One clock: drive, compare against the model (and optional fixed values), advance
    task automatic run_cycle(input stim_t s, input bit chk_fix, input logic [2:0] eg,
                             input bit chk_fix_rv, input logic [2:0] erv,
                             input bit chk_fix_rd, input logic [DW-1:0] erd);
        int            order [3];
        bit            req [4];
        int            who;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [3:0]    e_be;
        logic [2:0]    m_gnt, m_rv;
        bit            is_read;

        RST = s.rst; hold = s.hold;
        f_req = s.f_req; f_addr = s.f_addr;
        d_req = s.d_req; d_we = s.d_we; d_addr = s.d_addr; d_wdata = s.d_wdata; d_be = s.d_be;
        x_req = s.x_req; x_we = s.x_we; x_addr = s.x_addr; x_wdata = s.x_wdata; x_be = s.x_be;
        #3;

        req = '{0, s.f_req, s.d_req, s.x_req};
        who = 0;
        if (!s.rst && !s.hold) begin
            if (s.x_req && m_wait == int'(MAX_WAIT)) order = '{3, 2, 1};
            else                                     order = '{2, 1, 3};
            for (int k = 2; k >= 0; k--)
                if (req[order[k]]) who = order[k];
        end
        e_we = 0; e_addr = '0; e_wdata = '0; e_be = '0;
        case (who)
            1: begin e_addr = s.f_addr; e_be = 4'hF; end
            2: begin e_we = s.d_we; e_addr = s.d_addr; e_wdata = s.d_wdata; e_be = s.d_be; end
            3: begin e_we = s.x_we; e_addr = s.x_addr; e_wdata = s.x_wdata; e_be = s.x_be; end
            default: ;
        endcase
        m_gnt = {who == 3, who == 2, who == 1};
        m_rv  = s.rst ? 3'b000 : {m_owner == 3, m_owner == 2, m_owner == 1};

        chk("gnt", 32'({x_gnt, d_gnt, f_gnt}), 32'(m_gnt));
        chk("mem_en", 32'(mem_en), 32'(who != 0));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (who != 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_be", 32'(mem_be), 32'(e_be));
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        end
        chk("rvalid", 32'({x_rvalid, d_rvalid, f_rvalid}), 32'(m_rv));
        if (m_rv != 3'b000) chk("rdata", rdata, m_last_rd);
        if (chk_fix)    chk("vec_gnt", 32'({x_gnt, d_gnt, f_gnt}), 32'(eg));
        if (chk_fix_rv) chk("vec_rvalid", 32'({x_rvalid, d_rvalid, f_rvalid}), 32'(erv));
        if (chk_fix_rd) chk("vec_rdata", rdata, erd);

        is_read = (who != 0) && !e_we;
        if (s.rst) begin
            m_owner = 0;
            m_wait  = 0;
        end else begin
            m_owner = is_read ? who : 0;
            if (is_read) m_last_rd = shadow[e_addr[3:0]];
            if (who != 0 && e_we)
                for (int b = 0; b < 4; b++)
                    if (e_be[b]) shadow[e_addr[3:0]][8*b +: 8] = e_wdata[8*b +: 8];
            if (!s.hold) begin
                if (!s.x_req || who == 3)          m_wait = 0;
                else if (m_wait < int'(MAX_WAIT))  m_wait = m_wait + 1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    vec_t vecs [20];
    stim_t s;
    logic [2:0] seq_g [8];

    initial begin
        for (int i = 0; i < 16; i++) begin
            tb_mem[i] = (i == 0) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i * 32'h0101_0111);
            shadow[i] = tb_mem[i];
        end
        mem_rdata = '0;
        m_owner = 0; m_wait = 0; m_last_rd = '0;

        // rst hold  f  fa      d  we da      wdata         be     x  we xa
        vecs[0].s  = mk(1, 0, 1, 14'h010, 0, 0, '0, '0, '0, 0, 0, '0);
        vecs[1].s  = mk(0, 0, 1, 14'h010, 0, 0, '0, '0, '0, 0, 0, '0);
        vecs[2].s  = idle();
        vecs[3].s  = idle();
        vecs[4].s  = mk(0, 0, 1, 14'h010, 1, 0, 14'h020, '0, 4'hF, 0, 0, '0);
        vecs[5].s  = mk(0, 0, 1, 14'h010, 0, 0, '0, '0, '0, 0, 0, '0);
        vecs[6].s  = idle();
        vecs[7].s  = mk(0, 0, 0, '0, 1, 1, 14'h030, 32'h12345678, 4'b0011, 0, 0, '0);
        vecs[8].s  = idle();
        vecs[9].s  = mk(0, 0, 0, '0, 1, 0, 14'h021, '0, 4'hF, 0, 0, '0);
        vecs[10].s = mk(0, 1, 1, 14'h011, 0, 0, '0, '0, '0, 0, 0, '0);
        vecs[11].s = mk(0, 1, 1, 14'h011, 0, 0, '0, '0, '0, 0, 0, '0);
        vecs[12].s = mk(0, 1, 1, 14'h011, 0, 0, '0, '0, '0, 0, 0, '0);
        vecs[13].s = mk(0, 0, 1, 14'h011, 0, 0, '0, '0, '0, 0, 0, '0);
        vecs[14].s = idle();
        vecs[15].s = mk(0, 0, 1, 14'h012, 0, 0, '0, '0, '0, 0, 0, '0);
        vecs[16].s = mk(1, 0, 1, 14'h012, 0, 0, '0, '0, '0, 0, 0, '0);
        vecs[17].s = idle();
        vecs[18].s = mk(0, 0, 0, '0, 0, 0, '0, '0, '0, 1, 0, 14'h005);
        vecs[19].s = idle();
        seq_g = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        begin
            logic [2:0] g [20];
            logic [2:0] r [20];
            g = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000, 3'b010, 3'b000, 3'b010,
                  3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b100, 3'b000};
            r = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000,
                  3'b010, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
            for (int i = 0; i < 20; i++) begin
                vecs[i].gnt = g[i];
                vecs[i].rv  = r[i];
                vecs[i].chk_rd = (i == 2);
                vecs[i].rd  = 32'hDEADBEEF;
            end
        end

        for (int i = 0; i < 20; i++)
            run_cycle(vecs[i].s, 1, vecs[i].gnt, 1, vecs[i].rv, vecs[i].chk_rd, vecs[i].rd);

        // Aging: x refused four times behind d, granted on the fifth, then again from zero
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < 5; i++) begin
                s = mk(0, 0, 0, '0, 1, 0, 14'h003, '0, 4'hF, 1, 0, 14'h007);
                run_cycle(s, 1, (i == 4) ? 3'b100 : 3'b010, 0, '0, 0, '0);
            end
        run_cycle(idle(), 1, 3'b000, 0, '0, 0, '0);

        // Aging count frozen across hold
        seq_g = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b100};
        for (int i = 0; i < 8; i++) begin
            s = mk(0, (i >= 2 && i <= 4), 0, '0, 1, 0, 14'h004, '0, 4'hF, 1, 0, 14'h009);
            run_cycle(s, 1, seq_g[i], 0, '0, 0, '0);
        end
        run_cycle(idle(), 0, '0, 0, '0, 0, '0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            s = mk(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                   1'($urandom), 14'($urandom),
                   1'($urandom), 1'($urandom), 14'($urandom), $urandom, 4'($urandom),
                   1'($urandom), 1'($urandom), 14'($urandom));
            s.x_be = 4'($urandom);
            run_cycle(s, 0, '0, 0, '0, 0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
